// File: rtl/err_compute_if.sv
// Sensor-to-PID handshake bundle for the line-follower error engine.
// The producer of start/clr/readings uses master; the engine uses slave.
interface err_compute_if #(
    parameter int PAIRS = 4,
    parameter int IR_W  = 12,
    parameter int ERR_W = 16
);
    logic                  start;
    logic                  clr;
    logic [PAIRS*IR_W-1:0] IR_R;
    logic [PAIRS*IR_W-1:0] IR_L;
    logic [ERR_W-1:0]      error;
    logic                  err_vld;
    logic                  busy;

    modport master (
        output start, clr, IR_R, IR_L,
        input  error, err_vld, busy
    );

    modport slave (
        input  start, clr, IR_R, IR_L,
        output error, err_vld, busy
    );
endinterface

// File: rtl/err_compute_seq.sv
// Line-follower error engine: snapshots L/R sensor pairs, accumulates
// sum((L_k - R_k) * 2^(k*SHIFT_STEP)) over 2*PAIRS cycles, saturates to ERR_W.
module err_compute_seq #(
    parameter int PAIRS      = 4,
    parameter int IR_W       = 12,
    parameter int ERR_W      = 16,
    parameter int SHIFT_STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    err_compute_if.slave  bus
);
    localparam int ACC_W = IR_W + (PAIRS - 1) * SHIFT_STEP + 2;
    localparam int NOPS  = 2 * PAIRS;
    localparam int CNT_W = $clog2(NOPS);
    localparam int SAT_W = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NOPS - 1);
    localparam logic signed [SAT_W-1:0] ERR_MAX =
        {{(SAT_W - ERR_W + 1){1'b0}}, {(ERR_W - 1){1'b1}}};
    localparam logic signed [SAT_W-1:0] ERR_MIN =
        {{(SAT_W - ERR_W + 1){1'b1}}, {(ERR_W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                   state_reg;
    state_t                   state_next;
    logic [PAIRS*IR_W-1:0]    ir_r_reg;
    logic [PAIRS*IR_W-1:0]    ir_l_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic signed [ACC_W-1:0]  s1_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [ERR_W-1:0]         error_reg;
    logic                     err_vld_reg;
    logic signed [ACC_W-1:0]  op_arr [NOPS];
    logic signed [SAT_W-1:0]  acc_ext;
    logic [ERR_W-1:0]         sat_next;

    // Operand i: even -> -R_(i/2), odd -> +L_(i/2), weighted by a constant shift.
    generate
        for (genvar gi = 0; gi < NOPS; gi++) begin : g_op
            logic [IR_W-1:0]  raw;
            logic [ACC_W-1:0] mag;
            if (gi % 2 == 0) begin : g_right
                assign raw        = ir_r_reg[(gi/2)*IR_W +: IR_W];
                assign mag        = ACC_W'(raw) << ((gi/2) * SHIFT_STEP);
                assign op_arr[gi] = -$signed(mag);
            end else begin : g_left
                assign raw        = ir_l_reg[(gi/2)*IR_W +: IR_W];
                assign mag        = ACC_W'(raw) << ((gi/2) * SHIFT_STEP);
                assign op_arr[gi] = $signed(mag);
            end
        end
    endgenerate

    always_comb begin
        acc_ext = {{(SAT_W - ACC_W){acc_reg[ACC_W-1]}}, acc_reg};
        if (acc_ext > ERR_MAX) begin
            sat_next = ERR_MAX[ERR_W-1:0];
        end else if (acc_ext < ERR_MIN) begin
            sat_next = ERR_MIN[ERR_W-1:0];
        end else begin
            sat_next = acc_ext[ERR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.clr) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.start) state_next = ACCUM;
                ACCUM:   if (cnt_reg == CNT_LAST) state_next = DRAIN;
                DRAIN:   state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Stage 1 (s1_reg) selects the operand; stage 2 folds s1_reg into acc_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r_reg    <= '0;
            ir_l_reg    <= '0;
            cnt_reg     <= '0;
            s1_reg      <= '0;
            acc_reg     <= '0;
            error_reg   <= '0;
            err_vld_reg <= 1'b0;
        end else if (bus.clr) begin
            cnt_reg     <= '0;
            s1_reg      <= '0;
            acc_reg     <= '0;
            error_reg   <= '0;
            err_vld_reg <= 1'b0;
        end else begin
            err_vld_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        ir_r_reg <= bus.IR_R;
                        ir_l_reg <= bus.IR_L;
                        cnt_reg  <= '0;
                        s1_reg   <= '0;
                        acc_reg  <= '0;
                    end
                end
                ACCUM: begin
                    s1_reg  <= op_arr[cnt_reg];
                    acc_reg <= acc_reg + s1_reg;
                    if (cnt_reg != CNT_LAST) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    acc_reg <= acc_reg + s1_reg;
                end
                DONE: begin
                    error_reg   <= sat_next;
                    err_vld_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.error   = error_reg;
    assign bus.err_vld = err_vld_reg;
    assign bus.busy    = (state_reg != IDLE);
endmodule

// File: tb/tb_err_compute_seq.sv
// Directed bench for err_compute_seq with default parameters (4 pairs, 12-bit IR,
// 16-bit error, step 1); expected values are hand-computed per scenario.
module tb_err_compute_seq;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    err_compute_if #(.PAIRS(4), .IR_W(12), .ERR_W(16)) bus ();

    err_compute_seq #(.PAIRS(4), .IR_W(12), .ERR_W(16), .SHIFT_STEP(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] pack4(input int p0, input int p1, input int p2, input int p3);
        logic [11:0] a, b, c, d;
        a = p0[11:0]; b = p1[11:0]; c = p2[11:0]; d = p3[11:0];
        return {d, c, b, a};
    endfunction

    // Raises start so the next rising edge (E0) accepts it; returns at E0 + 1.
    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns the number of rising edges until err_vld is seen (-1 on timeout)
    // and how many sampled cycles before that had busy high.
    task automatic wait_vld(output int edges, output int busy_cnt);
        edges    = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.err_vld) begin
                edges = k;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if (bus.error !== 16'd0 || bus.err_vld !== 1'b0 || bus.busy !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_outputs: got error=%0d vld=%b busy=%b required 0/0/0",
                     $signed(bus.error), bus.err_vld, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b0 || bus.err_vld !== 1'b0) begin
            n_miss++;
            $display("FAIL idle_after_release: got busy=%b vld=%b required 0/0", bus.busy, bus.err_vld);
        end
        $display("reset: error=%0d vld=%b busy=%b", $signed(bus.error), bus.err_vld, bus.busy);
    endtask

    task automatic test_single_r0();
        int edges, bcnt;
        bus.IR_R = pack4(100, 0, 0, 0);
        bus.IR_L = pack4(0, 0, 0, 0);
        @(negedge clk);
        do_start();
        n_vec++;
        if (bus.busy !== 1'b1) begin
            n_miss++;
            $display("FAIL r0_busy_after_e0: got %b required 1", bus.busy);
        end
        wait_vld(edges, bcnt);
        $display("r0 run: error=%0d latency=%0d busy_cycles=%0d", $signed(bus.error), edges, bcnt + 1);
        n_vec++;
        if (edges != 10) begin
            n_miss++;
            $display("FAIL r0_latency: got %0d required 10", edges);
        end
        n_vec++;
        if (bcnt != 9 || bus.busy !== 1'b0) begin
            n_miss++;
            $display("FAIL r0_busy_window: got %0d extra busy cycles, busy=%b required 9, 0", bcnt, bus.busy);
        end
        n_vec++;
        if ($signed(bus.error) !== -16'sd100) begin
            n_miss++;
            $display("FAIL r0_error: got %0d required -100", $signed(bus.error));
        end
        @(negedge clk);
        n_vec++;
        if (bus.err_vld !== 1'b0 || $signed(bus.error) !== -16'sd100) begin
            n_miss++;
            $display("FAIL r0_pulse_hold: got vld=%b error=%0d required 0, -100", bus.err_vld, $signed(bus.error));
        end
    endtask

    task automatic test_weights();
        int edges, bcnt;
        bus.IR_L = pack4(10, 20, 30, 40);
        bus.IR_R = pack4(40, 30, 20, 10);
        do_start();
        wait_vld(edges, bcnt);
        $display("weights run: error=%0d latency=%0d", $signed(bus.error), edges);
        n_vec++;
        if ($signed(bus.error) !== 16'sd230 || edges != 10) begin
            n_miss++;
            $display("FAIL weights_error: got %0d at %0d required 230 at 10", $signed(bus.error), edges);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int edges, bcnt;
        bus.IR_L = pack4(4095, 4095, 4095, 4095);
        bus.IR_R = pack4(0, 0, 0, 0);
        do_start();
        wait_vld(edges, bcnt);
        $display("sat_pos run: error=%0d latency=%0d", $signed(bus.error), edges);
        n_vec++;
        if ($signed(bus.error) !== 16'sd32767) begin
            n_miss++;
            $display("FAIL sat_pos: got %0d required 32767", $signed(bus.error));
        end
        @(negedge clk);
        bus.IR_L = pack4(0, 0, 0, 0);
        bus.IR_R = pack4(4095, 4095, 4095, 4095);
        do_start();
        wait_vld(edges, bcnt);
        $display("sat_neg run: error=%0d latency=%0d", $signed(bus.error), edges);
        n_vec++;
        if ($signed(bus.error) !== -16'sd32768) begin
            n_miss++;
            $display("FAIL sat_neg: got %0d required -32768", $signed(bus.error));
        end
        @(negedge clk);
    endtask

    task automatic test_snapshot();
        int edges, bcnt, extra;
        bus.IR_L = pack4(0, 0, 0, 256);
        bus.IR_R = pack4(0, 0, 0, 0);
        do_start();
        @(posedge clk);
        #1;
        bus.IR_L = '0;
        bus.IR_R = '0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_vld(edges, bcnt);
        $display("snapshot run: error=%0d edges_after_e3=%0d", $signed(bus.error), edges);
        n_vec++;
        if ($signed(bus.error) !== 16'sd2048 || edges != 7) begin
            n_miss++;
            $display("FAIL snapshot_error: got %0d at %0d required 2048 at 7", $signed(bus.error), edges);
        end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.err_vld || bus.busy) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_miss++;
            $display("FAIL snapshot_no_queue: got %0d active cycles required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int edges, bcnt;
        bus.IR_L = pack4(1, 0, 0, 0);
        bus.IR_R = pack4(0, 0, 0, 0);
        do_start();
        wait_vld(edges, bcnt);
        n_vec++;
        if ($signed(bus.error) !== 16'sd1) begin
            n_miss++;
            $display("FAIL b2b_first: got %0d required 1", $signed(bus.error));
        end
        bus.IR_L = pack4(5, 0, 0, 0);
        do_start();
        n_vec++;
        if (bus.busy !== 1'b1 || bus.err_vld !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_accept: got busy=%b vld=%b required 1, 0", bus.busy, bus.err_vld);
        end
        wait_vld(edges, bcnt);
        $display("back_to_back run: error=%0d latency=%0d", $signed(bus.error), edges);
        n_vec++;
        if ($signed(bus.error) !== 16'sd5 || edges != 10) begin
            n_miss++;
            $display("FAIL b2b_second: got %0d at %0d required 5 at 10", $signed(bus.error), edges);
        end
        @(negedge clk);
    endtask

    task automatic test_clr();
        int seen;
        bus.IR_L = pack4(9, 9, 9, 9);
        bus.IR_R = pack4(0, 0, 0, 0);
        do_start();
        repeat (4) @(posedge clk);
        #1;
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
        $display("clr at E5: error=%0d vld=%b busy=%b", $signed(bus.error), bus.err_vld, bus.busy);
        n_vec++;
        if (bus.busy !== 1'b0 || bus.error !== 16'd0 || bus.err_vld !== 1'b0) begin
            n_miss++;
            $display("FAIL clr_abort: got busy=%b error=%0d vld=%b required 0/0/0",
                     bus.busy, $signed(bus.error), bus.err_vld);
        end
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.err_vld) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_miss++;
            $display("FAIL clr_no_result: got %0d pulses required 0", seen);
        end
        bus.clr   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.clr   = 1'b0;
        bus.start = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_miss++;
            $display("FAIL clr_blocks_start: got busy=%b required 0", bus.busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int edges, bcnt;
        bus.IR_L = pack4(7, 0, 0, 0);
        bus.IR_R = pack4(0, 0, 0, 0);
        do_start();
        wait_vld(edges, bcnt);
        n_vec++;
        if ($signed(bus.error) !== 16'sd7) begin
            n_miss++;
            $display("FAIL rst_pre_error: got %0d required 7", $signed(bus.error));
        end
        bus.IR_L = pack4(3, 3, 3, 3);
        do_start();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-run: error=%0d vld=%b busy=%b", $signed(bus.error), bus.err_vld, bus.busy);
        n_vec++;
        if (bus.busy !== 1'b0 || bus.error !== 16'd0 || bus.err_vld !== 1'b0) begin
            n_miss++;
            $display("FAIL rst_async: got busy=%b error=%0d vld=%b required 0/0/0",
                     bus.busy, $signed(bus.error), bus.err_vld);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.IR_L = pack4(1, 2, 3, 4);
        bus.IR_R = pack4(0, 0, 0, 0);
        @(negedge clk);
        do_start();
        wait_vld(edges, bcnt);
        $display("post-reset run: error=%0d latency=%0d", $signed(bus.error), edges);
        n_vec++;
        if ($signed(bus.error) !== 16'sd49 || edges != 10) begin
            n_miss++;
            $display("FAIL rst_recover: got %0d at %0d required 49 at 10", $signed(bus.error), edges);
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.clr   = 1'b0;
        bus.IR_R  = '0;
        bus.IR_L  = '0;
        test_reset();
        test_single_r0();
        test_weights();
        test_saturation();
        test_snapshot();
        test_back_to_back();
        test_clr();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/err_compute_seq.md
# err_compute_seq

Self-sequencing, parametrised line-follower error engine: it snapshots PAIRS left/right IR sensor pairs on a start strobe and accumulates a signed, binary-weighted error over 2*PAIRS cycles through a two-stage operand/accumulate pipeline. The result is saturated to ERR_W bits and presented with a one-cycle valid pulse. It sits between the IR sensor sampling logic and the PID controller. It replaces an externally sequenced datapath with internal FSM control, arbitrary pair count and weight step, and overflow saturation.

## Interface
- PAIRS, 4: number of left/right sensor pairs; pair 0 is innermost.
- IR_W, 12: unsigned width of each IR reading.
- ERR_W, 16: width of the signed error output.
- SHIFT_STEP, 1: weight exponent step; pair k is weighted 2^(k*SHIFT_STEP).
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new computation; honoured only when busy=0.
- clr  input  1  synchronous abort; highest priority after reset.
- IR_R  input  PAIRS*IR_W  right readings, pair k at IR_R[k*IR_W +: IR_W].
- IR_L  input  PAIRS*IR_W  left readings, same packing.
- error  output  ERR_W  signed saturated error, held between results.
- err_vld  output  1  one-cycle pulse; error was updated on the same edge.
- busy  output  1  high while a computation is in flight.

## Operation
- Error = sum over k of (L_k − R_k)·2^(k·SHIFT_STEP). Left readings are added and right readings are subtracted.
- Internal accumulator is signed, ACC_W = IR_W + (PAIRS−1)·SHIFT_STEP + 2 bits wide, so no overflow occurs before saturation.
- Snapshot: on an accepted start, all IR_L and IR_R are registered. Inputs may change freely afterwards.
- Operand order, index i = 0..2·PAIRS−1:
  - Even i selects R_(i/2) and negates it.
  - Odd i selects L_(i/2).
  - The operand is zero-extended, then shifted left by (i/2)·SHIFT_STEP.
- Pipeline stage 1 registers the selected, signed operand. Stage 2 adds the stage-1 register into the accumulator.
- FSM states:
  - IDLE: on start, capture the snapshot, clear the accumulator and counter, go to ACCUM.
  - ACCUM: counter steps 0..2·PAIRS−1, one operand per cycle. When the counter reaches 2·PAIRS−1, go to DRAIN.
  - DRAIN: the last operand is accumulated. Go to DONE.
  - DONE: saturate the accumulator to [−2^(ERR_W−1), 2^(ERR_W−1)−1], load error, set err_vld. Go to IDLE.
- busy = (state != IDLE).
- start while busy is ignored, not queued.
- clr, any state: state goes to IDLE, error goes to 0, err_vld goes to 0, the accumulator and pipeline are cleared. Any start in the same cycle is ignored.
- clr and err_vld:
  - clr is sampled on the same edge as the DONE→IDLE transition, so that edge loads error = 0 and err_vld = 0.
  - clr asserted during the cycle after that edge (when err_vld is already high) forces err_vld = 0 and error = 0 on the next edge, which is also the edge where err_vld would drop anyway.
- Reset values: error = 0, err_vld = 0, busy = 0, state = IDLE, snapshot/accumulator/pipeline = 0.

## Timing
- E0 is the edge that samples start=1 with busy=0.
- busy is high from E0 until the edge E(2·PAIRS+2).
- The last operand enters stage 1 at E(2·PAIRS) and is accumulated at E(2·PAIRS+1).
- Result: error and err_vld are updated at E(2·PAIRS+2). Latency is 2·PAIRS+2 clocks; this is 10 clocks for PAIRS=4.
- err_vld is high for exactly one cycle, during which busy=0.
- A start in the err_vld cycle is accepted, so back-to-back throughput is one result per 2·PAIRS+2 clocks.
- error is stable between err_vld pulses.
- rst_n asserted at any time clears all outputs immediately, independent of clk.

## Test plan
All scenarios use default parameters (PAIRS=4, IR_W=12, ERR_W=16, SHIFT_STEP=1).
- R0=100, all others 0, start at E0 → err_vld only in the cycle after E10, error = −100, busy high for 10 cycles.
- L = {10,20,30,40}, R = {40,30,20,10} (pair 0 first) → error = 490 − 260 = 230.
- All L=4095, R=0 → error = 32767 (saturated from 61425). All R=4095, L=0 → error = −32768.
- Start with L3=256, then change all inputs to 0 one cycle after E0, and pulse start again at E3 → error = 2048, no second result.
- Second start in the err_vld cycle with L0=5 → next err_vld 10 cycles later, error = 5.
- Abort and reset:
  - clr at E5 of a run → busy=0 after E5, error = 0, no err_vld.
  - rst_n low mid-run → outputs 0 immediately, and a new start after release computes correctly.
